// File: rtl/clock_pkg.sv
// Shared definitions for the clock controller: edit-state encoding and field limits.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } edit_state_t;

    localparam logic [5:0] SEC_MAX   = 6'd59;
    localparam logic [5:0] MIN_MAX   = 6'd59;
    localparam logic [4:0] HOUR_MAX  = 5'd23;
    localparam logic [4:0] HOUR_NOON = 5'd12;

endpackage

// File: rtl/h24Toh12.sv
// Combinational 24-hour to 12-hour converter; hour 0 reads as 12, pm set from 12:00 onward.
module h24Toh12
    import clock_pkg::*;
(
    input  logic [4:0] hour24_i,
    output logic [4:0] hour12_o,
    output logic       pm_o
);

    assign pm_o = (hour24_i >= HOUR_NOON);

    always_comb begin
        if (hour24_i == 5'd0) begin
            hour12_o = HOUR_NOON;
        end else if (hour24_i > HOUR_NOON) begin
            hour12_o = hour24_i - HOUR_NOON;
        end else begin
            hour12_o = hour24_i;
        end
    end

endmodule

// File: rtl/clock_ctrl.sv
// Time-of-day clock with button-driven hour/minute editing and 12/24-hour display.
// Optional blink toggle register enabled by defining CLOCK_CTRL_BLINK_EN.
module clock_ctrl
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       fmt12,
    output logic [4:0] hour_disp,
    output logic       pm,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [1:0] edit_state,
    output logic       day_wrap,
    output logic       blink
);

    logic [1:0] state_q, state_d;
    logic [4:0] hour_q, hour_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic       day_wrap_q, day_wrap_d;
    logic [4:0] hour12;

    // btn_mode always wins: it swallows a same-cycle tick or increment.
    always_comb begin
        state_d    = state_q;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        day_wrap_d = 1'b0;
        case (state_q)
            RUN: begin
                if (btn_mode) begin
                    state_d = SET_HOUR;
                    sec_d   = '0;
                end else if (tick_1hz) begin
                    if (sec_q == SEC_MAX) begin
                        sec_d = '0;
                        if (min_q == MIN_MAX) begin
                            min_d = '0;
                            if (hour_q == HOUR_MAX) begin
                                hour_d     = '0;
                                day_wrap_d = 1'b1;
                            end else begin
                                hour_d = hour_q + 5'd1;
                            end
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
            end
            SET_HOUR: begin
                if (btn_mode) begin
                    state_d = SET_MIN;
                end else if (btn_inc) begin
                    hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + 5'd1;
                end
            end
            SET_MIN: begin
                if (btn_mode) begin
                    state_d = RUN;
                end else if (btn_inc) begin
                    min_d = (min_q == MIN_MAX) ? '0 : min_q + 6'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            day_wrap_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            day_wrap_q <= day_wrap_d;
        end
    end

`ifdef CLOCK_CTRL_BLINK_EN
    logic blink_q, blink_d;

    always_comb begin
        blink_d = blink_q;
        if ((state_d == RUN) || ((state_q == RUN) && (state_d == SET_HOUR))) begin
            blink_d = 1'b1;
        end else if (tick_1hz) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q <= 1'b1;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b1;
`endif

    h24Toh12 u_h24Toh12 (
        .hour24_i (hour_q),
        .hour12_o (hour12),
        .pm_o     (pm)
    );

    assign hour_disp  = fmt12 ? hour12 : hour_q;
    assign minute     = min_q;
    assign second     = sec_q;
    assign edit_state = state_q;
    assign day_wrap   = day_wrap_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: directed scenarios plus random traffic against a seconds-of-day model.
module tb_clock_ctrl;

    logic       clk = 1'b0;
    logic       rst, tick_1hz, btn_mode, btn_inc, fmt12;
    logic [4:0] hour_disp;
    logic       pm;
    logic [5:0] minute, second;
    logic [1:0] edit_state;
    logic       day_wrap, blink;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    // Reference model: time kept as seconds of the day, mode as 0/1/2.
    int m_tod   = 0;
    int m_mode  = 0;
    bit m_dw    = 1'b0;
    bit m_blink = 1'b1;
    int dw_seen = 0;

    clock_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .fmt12      (fmt12),
        .hour_disp  (hour_disp),
        .pm         (pm),
        .minute     (minute),
        .second     (second),
        .edit_state (edit_state),
        .day_wrap   (day_wrap),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_disp(input int tod, input bit f12);
        int h;
        h = tod / 3600;
        if (!f12) return h;
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    task automatic chk_all(input string tag);
        chk({tag, ".hour_disp"}, 32'(hour_disp), 32'(exp_disp(m_tod, fmt12)));
        chk({tag, ".pm"},        32'(pm),        32'((m_tod / 3600) >= 12));
        chk({tag, ".minute"},    32'(minute),    32'((m_tod / 60) % 60));
        chk({tag, ".second"},    32'(second),    32'(m_tod % 60));
        chk({tag, ".state"},     32'(edit_state), 32'(m_mode));
        chk({tag, ".day_wrap"},  32'(day_wrap),  32'(m_dw));
        chk({tag, ".blink"},     32'(blink),     32'(m_blink));
    endtask

    task automatic model(input bit r, input bit t, input bit md, input bit inc);
        int h, mi, s, prev_mode;
        prev_mode = m_mode;
        h  = m_tod / 3600;
        mi = (m_tod / 60) % 60;
        s  = m_tod % 60;
        m_dw = 1'b0;
        if (r) begin
            m_tod = 0; m_mode = 0; m_blink = 1'b1;
            return;
        end
        if (md) begin
            m_mode = (m_mode + 1) % 3;
            if (m_mode == 1) s = 0;
        end else if (m_mode == 0 && t) begin
            m_tod = (m_tod + 1) % 86400;
            m_dw  = (m_tod == 0);
            h  = m_tod / 3600;
            mi = (m_tod / 60) % 60;
            s  = m_tod % 60;
        end else if (m_mode == 1 && inc) begin
            h = (h + 1) % 24;
        end else if (m_mode == 2 && inc) begin
            mi = (mi + 1) % 60;
        end
        m_tod = h * 3600 + mi * 60 + s;
`ifdef CLOCK_CTRL_BLINK_EN
        if (m_mode == 0 || (prev_mode == 0 && m_mode == 1)) m_blink = 1'b1;
        else if (t) m_blink = ~m_blink;
`else
        m_blink = 1'b1;
`endif
    endtask

    task automatic step(input bit r, input bit t, input bit md, input bit inc, input string tag);
        rst = r; tick_1hz = t; btn_mode = md; btn_inc = inc;
        @(posedge clk);
        model(r, t, md, inc);
        #1;
        if (day_wrap === 1'b1) dw_seen++;
        chk_all(tag);
        rst = 1'b0; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    endtask

    task automatic set_time(input int h, input int mi);
        step(1'b0, 1'b0, 1'b1, 1'b0, "to_sethour");
        for (int i = 0; i < h; i++) step(1'b0, 1'b0, 1'b0, 1'b1, "inc_hour");
        step(1'b0, 1'b0, 1'b1, 1'b0, "to_setmin");
        for (int i = 0; i < mi; i++) step(1'b0, 1'b0, 1'b0, 1'b1, "inc_min");
        step(1'b0, 1'b0, 1'b1, 1'b0, "to_run");
    endtask

    initial begin
        rst = 1'b0; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; fmt12 = 1'b1;
        #2;

        // Reset in 12-hour mode.
        step(1'b1, 1'b0, 1'b0, 1'b0, "reset");
        chk("reset.disp12", 32'(hour_disp), 32'd12);
        chk("reset.pm0", 32'(pm), 32'd0);
        fmt12 = 1'b0; #1;
        chk("reset.disp24", 32'(hour_disp), 32'd0);

        // Rollover 23:59:00 + 60 ticks.
        set_time(23, 59);
        chk("roll.pre_sec", 32'(second), 32'd0);
        dw_seen = 0;
        for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 1'b0, 1'b0, "roll_tick");
        chk("roll.dw_high", 32'(day_wrap), 32'd1);
        chk("roll.hour0", 32'(hour_disp), 32'd0);
        chk("roll.min0", 32'(minute), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, "roll_after");
        chk("roll.dw_once", 32'(dw_seen), 32'd1);

        // Display mapping at 13h and 12h.
        step(1'b1, 1'b0, 1'b0, 1'b0, "reset2");
        fmt12 = 1'b1;
        set_time(13, 0);
        chk("disp13.h12", 32'(hour_disp), 32'd1);
        chk("disp13.pm", 32'(pm), 32'd1);
        fmt12 = 1'b0; #1;
        chk("disp13.h24", 32'(hour_disp), 32'd13);
        fmt12 = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, "reset3");
        set_time(12, 0);
        chk("disp12.h12", 32'(hour_disp), 32'd12);
        chk("disp12.pm", 32'(pm), 32'd1);

        // Edit wrap: 24 hour increments, 60 minute increments.
        fmt12 = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, "reset4");
        set_time(24, 60);
        chk("wrap.hour", 32'(hour_disp), 32'd0);
        chk("wrap.min", 32'(minute), 32'd0);
        chk("wrap.sec", 32'(second), 32'd0);

        // Simultaneous mode+inc in SET_HOUR at hour 5.
        step(1'b1, 1'b0, 1'b0, 1'b0, "reset5");
        step(1'b0, 1'b0, 1'b1, 1'b0, "sim_sethour");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, "sim_inc");
        step(1'b0, 1'b0, 1'b1, 1'b1, "sim_mode_inc");
        chk("sim.state", 32'(edit_state), 32'd2);
        chk("sim.hour", 32'(hour_disp), 32'd5);

        // Tick+mode in RUN at 10:20:59.
        step(1'b1, 1'b0, 1'b0, 1'b0, "reset6");
        set_time(10, 20);
        for (int i = 0; i < 59; i++) step(1'b0, 1'b1, 1'b0, 1'b0, "to_59");
        chk("tm.sec59", 32'(second), 32'd59);
        step(1'b0, 1'b1, 1'b1, 1'b0, "tick_mode");
        chk("tm.state", 32'(edit_state), 32'd1);
        chk("tm.min", 32'(minute), 32'd20);
        chk("tm.sec", 32'(second), 32'd0);

        // Reset mid-edit in SET_MIN at minute 30.
        step(1'b0, 1'b0, 1'b1, 1'b0, "me_setmin");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1, "me_inc");
        chk("me.min30", 32'(minute), 32'd30);
        step(1'b1, 1'b1, 1'b1, 1'b1, "me_reset");
        chk("me.state", 32'(edit_state), 32'd0);
        chk("me.hour", 32'(hour_disp), 32'd0);
        chk("me.min", 32'(minute), 32'd0);

        // Random traffic, dense ticks, sparse buttons and resets.
        for (int i = 0; i < 3000; i++) begin
            fmt12 = ($urandom_range(0, 15) == 0) ? ~fmt12 : fmt12;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_ctrl.md
CLOCK_CTRL -- requirements
Module: clock_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port tick_1hz, input, 1 bit: one-cycle strobe, once per second.
REQ-004 SHALL have port btn_mode, input, 1 bit: one-cycle pulse, already debounced; advances the edit state.
REQ-005 SHALL have port btn_inc, input, 1 bit: one-cycle pulse, already debounced; increments the field being edited.
REQ-006 SHALL have port fmt12, input, 1 bit: 1 selects 12-hour display, 0 selects 24-hour display.
REQ-007 SHALL have port hour_disp, output, 5 bits: displayed hour, 0-23 when fmt12=0, 1-12 when fmt12=1.
REQ-008 SHALL have port pm, output, 1 bit: 1 when the internal hour is greater than 11, in both formats.
REQ-009 SHALL have port minute, output, 6 bits: 0-59.
REQ-010 SHALL have port second, output, 6 bits: 0-59.
REQ-011 SHALL have port edit_state, output, 2 bits: 0=RUN, 1=SET_HOUR, 2=SET_MIN.
REQ-012 SHALL have port day_wrap, output, 1 bit: one-cycle strobe on rollover from 23:59:59 to 00:00:00.
REQ-013 SHALL have port blink, output, 1 bit: display blink enable for the edited field.

Function
REQ-014 SHALL hold the hour (0-23), minute and second registers; every register update becomes visible one cycle after the triggering input.
REQ-015 SHALL, in RUN on tick_1hz, increment second; on a second wrap 59->0, increment minute; on a minute wrap 59->0, increment hour; hour wraps 23->0.
REQ-016 SHALL assert day_wrap for exactly the one cycle in which the time registers show 00:00:00 after a RUN rollover; day_wrap SHALL never assert from edits.
REQ-017 SHALL sequence the states on btn_mode: RUN->SET_HOUR->SET_MIN->RUN; state 3 is illegal and SHALL recover to RUN on the next cycle.
REQ-018 SHALL clear second to 0 on entry to SET_HOUR and hold all counting (tick_1hz ignored for time) in SET_HOUR and SET_MIN.
REQ-019 SHALL, on btn_inc, increment hour in SET_HOUR (23->0) or minute in SET_MIN (59->0), with no carry into other fields; btn_inc in RUN SHALL be ignored.
REQ-020 SHALL give btn_mode priority when btn_mode and btn_inc are high in the same cycle: the state advances and the increment is dropped.
REQ-021 SHALL, when tick_1hz and btn_mode are high in the same cycle in RUN, enter SET_HOUR, drop the tick (no carry) and clear second.
REQ-022 SHALL derive hour_disp and pm combinationally from the hour register and fmt12: for fmt12=1, hours 0 and 12 map to 12 and hours 13-23 map to hour-12; a change of fmt12 SHALL be visible in the same cycle.

Reset
REQ-023 SHALL, on rst, set hour=0, minute=0, second=0, state=RUN, day_wrap=0 and blink=1; hour_disp SHALL then read 0 (fmt12=0) or 12 (fmt12=1), with pm=0.
REQ-024 SHALL give rst priority over all other inputs in any state, including mid-edit.

Configuration
REQ-025 SHALL support the macro CLOCK_CTRL_BLINK_EN.
- Defined: blink toggles on each tick_1hz while in SET_HOUR or SET_MIN, is set to 1 on entering SET_HOUR, and is forced to 1 in RUN.
- Undefined: blink is constant 1 and no toggle register is implemented.

Structure
REQ-026 SHALL take from shared package clock_pkg: the edit-state enum (RUN, SET_HOUR, SET_MIN) and the constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
REQ-027 SHALL instantiate the existing h24Toh12 converter as its single sub-module for the 12-hour mapping; the counters and FSM are local to clock_ctrl.

Verification
REQ-028 SHALL cover reset:
- Stimulus: rst=1 for 1 cycle, with fmt12=1.
- Required: hour_disp=12, pm=0, minute=0, second=0, edit_state=0.
REQ-029 SHALL cover rollover:
- Stimulus: set 23:59 by edits, return to RUN, then 60 ticks.
- Required: 00:00:00 and day_wrap high for exactly 1 cycle.
REQ-030 SHALL cover the display mapping:
- Stimulus: hour=13 with fmt12=1.
- Required: hour_disp=1, pm=1.
- Then: fmt12=0 gives hour_disp=13 in the same cycle; hour=12 with fmt12=1 gives hour_disp=12, pm=1.
REQ-031 SHALL cover edit wrap:
- Stimulus: in SET_HOUR from hour 0, 24 btn_inc pulses; in SET_MIN from minute 0, 60 pulses.
- Required: hour=0 and minute=0, hour unaffected by the minute wrap, second=0 throughout.
REQ-032 SHALL cover simultaneous inputs:
- Stimulus: btn_mode+btn_inc in SET_HOUR with hour=5.
- Required: edit_state=2, hour=5.
- Stimulus: tick+btn_mode in RUN at 10:20:59.
- Required: SET_HOUR at 10:20:00.
REQ-033 SHALL cover reset mid-edit:
- Stimulus: rst asserted in SET_MIN with minute=30.
- Required: next cycle edit_state=0 and 00:00:00.
